// File: rtl/cdm_pkg.sv
// cdm_pkg: shared types and widths for the carry-disregard error accumulator.
// Optional squared-error path is enabled by defining SQ_ERR_EN.
package cdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WIDTH_D = 8;
    localparam int CNT_W_D = 17;
    localparam int SUM_W_D = 32;
    localparam int SQ_W_D  = 48;

    // All-ones value of a w-bit saturating accumulator
    function automatic logic [63:0] sat_lim(input int w);
        sat_lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/cdm_ed_stage.sv
// cdm_ed_stage: S1 exact product, S2 absolute error distance (and square).
// Square output exists only when SQ_ERR_EN is defined.
module cdm_ed_stage
    import cdm_pkg::*;
#(
    parameter int WIDTH = WIDTH_D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   r,
    output logic                 s1_valid,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
`ifdef SQ_ERR_EN
    output logic [4*WIDTH-1:0]   ed_sq,
`endif
    output logic [2*WIDTH-1:0]   ed
);

    localparam int PW = 2 * WIDTH;

    logic             v1;
    logic [WIDTH-1:0] a1, b1;
    logic [PW-1:0]    r1, exact1;
    logic [PW:0]      diff;
    logic [PW-1:0]    ed_c;

    // S1: capture operands, approximate product and exact product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            r1     <= '0;
            exact1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1     <= a;
                b1     <= b;
                r1     <= r;
                exact1 <= PW'(a) * PW'(b);
            end
        end
    end

    // Absolute difference, one extra bit to catch the sign
    always_comb begin
        diff = {1'b0, exact1} - {1'b0, r1};
        ed_c = diff[PW] ? PW'({1'b0, r1} - {1'b0, exact1})
                        : diff[PW-1:0];
    end

    // S2: register error distance alongside its operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            ed        <= '0;
`ifdef SQ_ERR_EN
            ed_sq     <= '0;
`endif
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_a <= a1;
                out_b <= b1;
                ed    <= ed_c;
`ifdef SQ_ERR_EN
                ed_sq <= (2*PW)'(ed_c) * (2*PW)'(ed_c);
`endif
            end
        end
    end

    assign s1_valid = v1;

endmodule

// File: rtl/cdm_err_acc.sv
// cdm_err_acc: frame FSM and saturating error-metric accumulators.
// Define SQ_ERR_EN to add the sum_sq squared-error accumulator.
module cdm_err_acc
    import cdm_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int CNT_W = CNT_W_D,
    parameter int SUM_W = SUM_W_D,
    parameter int SQ_W  = SQ_W_D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 last,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2*WIDTH-1:0]   R,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b,
`ifdef SQ_ERR_EN
    output logic [SQ_W-1:0]      sum_sq,
`endif
    output logic                 ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_lim(CNT_W));
    localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(sat_lim(SUM_W));

    state_t             state, state_nx;
    logic               accept, clr;
    logic               s1_v, s2_v;
    logic [WIDTH-1:0]   s2_a, s2_b;
    logic [2*WIDTH-1:0] ed;
    logic [SUM_W:0]     sum_nx;
`ifdef SQ_ERR_EN
    localparam logic [SQ_W-1:0] SQ_MAX = SQ_W'(sat_lim(SQ_W));
    logic [4*WIDTH-1:0] ed_sq;
    logic [SQ_W:0]      sq_nx;
`endif

    assign accept = in_valid && in_ready;
    assign clr    = start && (state == IDLE || state == DONE);

    cdm_ed_stage #(.WIDTH(WIDTH)) u_ed (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .a         (A),
        .b         (B),
        .r         (R),
        .s1_valid  (s1_v),
        .out_valid (s2_v),
        .out_a     (s2_a),
        .out_b     (s2_b),
`ifdef SQ_ERR_EN
        .ed_sq     (ed_sq),
`endif
        .ed        (ed)
    );

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; DRAIN ends as S2 retires
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                in_ready = 1'b1;
                if (accept && last) state_nx = DRAIN;
            end
            DRAIN: if (!s1_v) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Wide sums expose the carry used for saturation
    always_comb begin
        sum_nx = {1'b0, sum_ed} + (SUM_W+1)'(ed);
`ifdef SQ_ERR_EN
        sq_nx  = {1'b0, sum_sq} + (SQ_W+1)'(ed_sq);
`endif
    end

    // Accumulate each retiring S2 sample; start clears the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            max_a        <= '0;
            max_b        <= '0;
            ovf          <= 1'b0;
`ifdef SQ_ERR_EN
            sum_sq       <= '0;
`endif
        end else if (s2_v) begin
            if (sample_count != CNT_MAX)
                sample_count <= sample_count + CNT_W'(1);
            if (ed != '0 && err_count != CNT_MAX)
                err_count <= err_count + CNT_W'(1);
            if (sum_nx[SUM_W]) begin
                sum_ed <= SUM_MAX;
                ovf    <= 1'b1;
            end else begin
                sum_ed <= sum_nx[SUM_W-1:0];
            end
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= s2_a;
                max_b  <= s2_b;
            end
`ifdef SQ_ERR_EN
            if (sq_nx[SQ_W]) begin
                sum_sq <= SQ_MAX;
                ovf    <= 1'b1;
            end else begin
                sum_sq <= sq_nx[SQ_W-1:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_cdm_err_acc.sv
// tb_cdm_err_acc: directed vectors for the error-metric accumulator.
// Built with SUM_W = 16 so the saturation case is reachable.
module tb_cdm_err_acc;

    localparam int W  = 8;
    localparam int CW = 17;
    localparam int SW = 16;
    localparam int QW = 48;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            last = 1'b0;
    logic [W-1:0]    A = '0;
    logic [W-1:0]    B = '0;
    logic [2*W-1:0]  R = '0;
    logic            in_ready, out_valid, ovf;
    logic [CW-1:0]   sample_count, err_count;
    logic [SW-1:0]   sum_ed;
    logic [2*W-1:0]  max_ed;
    logic [W-1:0]    max_a, max_b;
`ifdef SQ_ERR_EN
    logic [QW-1:0]   sum_sq;
`endif

    int n_vec = 0;
    int n_err = 0;

    cdm_err_acc #(.WIDTH(W), .CNT_W(CW), .SUM_W(SW), .SQ_W(QW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .last         (last),
        .A            (A),
        .B            (B),
        .R            (R),
        .out_valid    (out_valid),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_ed       (sum_ed),
        .max_ed       (max_ed),
        .max_a        (max_a),
        .max_b        (max_b),
`ifdef SQ_ERR_EN
        .sum_sq       (sum_sq),
`endif
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic s, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] r, input logic l);
        @(negedge clk);
        start = s; in_valid = v; A = a; B = b; R = r; last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!out_valid && k < 8) begin
            idle();
            k++;
        end
        chk(tag, 64'(out_valid), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"}, 64'(sample_count), 0);
        chk({tag, "_err"}, 64'(err_count), 0);
        chk({tag, "_sum"}, 64'(sum_ed), 0);
        chk({tag, "_max"}, 64'(max_ed), 0);
        chk({tag, "_ma"}, 64'(max_a), 0);
        chk({tag, "_mb"}, 64'(max_b), 0);
        chk({tag, "_ovf"}, 64'(ovf), 0);
        chk({tag, "_ov"}, 64'(out_valid), 0);
        chk({tag, "_rdy"}, 64'(in_ready), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk_all_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        idle();
        chk("idle_rdy", 64'(in_ready), 0);

        // Exact stream
        tick(1, 0, 0, 0, 0, 0);
        chk("run_rdy", 64'(in_ready), 1);
        tick(0, 1, 3, 5, 15, 0);
        tick(0, 1, 0, 200, 0, 0);
        tick(0, 1, 255, 255, 65025, 0);
        tick(0, 1, 17, 9, 153, 1);
        chk("drain_rdy", 64'(in_ready), 0);
        chk("lat0", 64'(out_valid), 0);
        idle();
        chk("lat1", 64'(out_valid), 0);
        idle();
        chk("lat2", 64'(out_valid), 1);
        chk("ex_cnt", 64'(sample_count), 4);
        chk("ex_err", 64'(err_count), 0);
        chk("ex_sum", 64'(sum_ed), 0);
        chk("ex_max", 64'(max_ed), 0);
        chk("ex_ma", 64'(max_a), 0);
        chk("ex_mb", 64'(max_b), 0);
        chk("ex_ovf", 64'(ovf), 0);
        chk("done_rdy", 64'(in_ready), 0);

        // Errors and max; restart from DONE
        tick(1, 0, 0, 0, 0, 0);
        chk("rs_ov", 64'(out_valid), 0);
        chk("rs_cnt", 64'(sample_count), 0);
        tick(0, 1, 255, 255, 64769, 0);
        tick(0, 1, 12, 12, 160, 0);
        tick(0, 1, 200, 100, 19744, 1);
        idle();
        idle();
        chk("er_ov", 64'(out_valid), 1);
        chk("er_cnt", 64'(sample_count), 3);
        chk("er_err", 64'(err_count), 3);
        chk("er_sum", 64'(sum_ed), 528);
        chk("er_max", 64'(max_ed), 256);
        chk("er_ma", 64'(max_a), 255);
        chk("er_mb", 64'(max_b), 255);
`ifdef SQ_ERR_EN
        chk("er_sq", 64'(sum_sq), 131328);
`endif

        // Handshake: valid held in DONE is ignored
        tick(0, 1, 9, 9, 0, 1);
        tick(0, 1, 9, 9, 0, 1);
        chk("hd_cnt", 64'(sample_count), 3);
        chk("hd_ov", 64'(out_valid), 1);
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 2, 3, 6, 0);
        tick(0, 0, 50, 50, 0, 1);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 4, 4, 20, 0);
        tick(0, 1, 1, 1, 0, 1);
        idle();
        idle();
        chk("hs_ov", 64'(out_valid), 1);
        chk("hs_cnt", 64'(sample_count), 3);
        chk("hs_err", 64'(err_count), 2);
        chk("hs_sum", 64'(sum_ed), 5);
        chk("hs_max", 64'(max_ed), 4);
        chk("hs_ma", 64'(max_a), 4);
        chk("hs_mb", 64'(max_b), 4);

        // Saturation with 16-bit sum
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 255, 255, 25025, 0);
        tick(0, 1, 255, 255, 25025, 1);
        wait_done("sat_done");
        chk("sat_sum", 64'(sum_ed), 65535);
        chk("sat_ovf", 64'(ovf), 1);
        chk("sat_max", 64'(max_ed), 40000);
        idle();
        idle();
        idle();
        chk("sat_stky", 64'(ovf), 1);
        tick(1, 0, 0, 0, 0, 0);
        chk("sat_clr", 64'(ovf), 0);
        chk("sat_sclr", 64'(sum_ed), 0);

        // Exhaustive exact sweep
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                tick(0, 1, 8'(a), 8'(b), 16'(a * b),
                     (a == 255 && b == 255));
            end
        end
        wait_done("sw_done");
        chk("sw_cnt", 64'(sample_count), 65536);
        chk("sw_err", 64'(err_count), 0);
        chk("sw_sum", 64'(sum_ed), 0);
        chk("sw_ovf", 64'(ovf), 0);

        // Reset mid-frame
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 10, 10, 90, 0);
        tick(0, 1, 10, 10, 90, 0);
        tick(0, 1, 10, 10, 90, 0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk_all_zero("mrst");
        @(negedge clk) rst_n = 1'b1;
        tick(0, 1, 5, 5, 0, 1);
        tick(0, 1, 5, 5, 0, 1);
        idle();
        idle();
        chk("ir_cnt", 64'(sample_count), 0);
        chk("ir_rdy", 64'(in_ready), 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("ir_run", 64'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdm_err_acc.md
Name: cdm_err_acc

Overview:
- Streaming error-metric accumulator directly downstream of the 8x8 carry-disregard approximate multiplier.
- Consumes operand pairs (A, B) and the approximate product R, recomputes the exact product internally, and accumulates over one frame:
  - error distance (ED) statistics,
  - error count,
  - maximum ED and the operands that produced it.
- Replaces offline text-dump post-processing. Characterisation runs such as the exhaustive 256x256 sweep yield ER/MED directly in hardware.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- CNT_W, 17, width of sample and error counters; 2^16 samples must fit.
- SUM_W, 32, width of the ED sum accumulator.
- SQ_W, 48, width of the squared-ED accumulator (SQ_ERR_EN only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear accumulators and arm a frame.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- last  in  1  qualifies the final sample of the frame.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- R  in  2*WIDTH  approximate product from the multiplier.
- out_valid  out  1  frame results stable.
- sample_count  out  CNT_W  samples accepted.
- err_count  out  CNT_W  samples with ED != 0.
- sum_ed  out  SUM_W  sum of ED, saturating.
- max_ed  out  2*WIDTH  largest ED seen.
- max_a  out  WIDTH  A of the first sample reaching max_ed.
- max_b  out  WIDTH  B of the same sample.
- ovf  out  1  sticky: sum_ed (or sum_sq) saturated.

Behaviour:
- Reset: asynchronous, active-low. All outputs, accumulators and pipeline valids go to 0. FSM enters IDLE.
- FSM states:
  - IDLE:
    - in_ready = 0.
    - start -> clear accumulators, go to RUN.
  - RUN:
    - in_ready = 1.
    - Accept when in_valid && in_ready.
    - Accepted sample with last = 1 -> DRAIN.
  - DRAIN:
    - in_ready = 0.
    - Wait until both pipeline stages are empty (exactly 2 cycles after the last accept) -> DONE.
  - DONE:
    - out_valid = 1; results held.
    - start -> clear accumulators, out_valid = 0, go to RUN in the same cycle.
- start is ignored in RUN and DRAIN.
- Pipeline:
  - S1 registers A, B, R and exact = A*B (unsigned, 2*WIDTH bits).
  - S2 registers ED = |exact - R|. Computed in 2*WIDTH+1 bits; ED fits 2*WIDTH.
  - Accumulators update on the cycle after the S2 register.
  - Accept-to-accumulator latency: 2 cycles.
  - Gaps in in_valid propagate as bubbles; no other stall source exists.
- Accumulation per valid S2 sample:
  - sample_count += 1.
  - err_count += (ED != 0).
  - sum_ed += ED. On overflow, clamp to all-ones and set ovf.
- Max tracking:
  - Update max_ed/max_a/max_b only when ED > max_ed (strict). Ties keep the first occurrence.
  - ED = 0 never updates max_a/max_b.
- Counter saturation: sample_count and err_count saturate at all-ones. This is unreachable with CNT_W = 17 and a 65536-sample frame.
- last on a cycle without in_valid is ignored.
- Reset mid-frame: discards everything, returns to IDLE.
- Results remain readable in any state. out_valid alone marks them final.

Optional Feature:
- Macro SQ_ERR_EN.
- Defined:
  - Extra output sum_sq [SQ_W-1:0].
  - S2 also registers ED*ED.
  - sum_sq accumulates ED*ED, saturating; saturation also sets ovf.
  - sum_sq clears on start; reset value 0.
- Undefined: no port, no squarer, no accumulator. All other behaviour is identical.

Decomposition:
- Shared package cdm_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE),
  - default widths,
  - a helper for the saturating-add limit.
- One natural sub-module: cdm_ed_stage. It holds S1+S2 (exact product, absolute difference, optional square) with valid pass-through.
- The top holds the FSM and accumulators.

Test Plan:
- Exact stream:
  - Stimulus: start; 4 samples (3,5,R=15), (0,200,R=0), (255,255,R=65025), (17,9,R=153, last).
  - Required: out_valid 2 cycles after the last accept; sample_count = 4, err_count = 0, sum_ed = 0, max_ed = 0, max_a = max_b = 0, ovf = 0.
- Errors and max:
  - Stimulus: (255,255,R=64769), (12,12,R=160), (200,100,R=19744, last).
  - Required: EDs 256, 16, 256; err_count = 3, sum_ed = 528, max_ed = 256, max_a = 255, max_b = 255 (tie keeps first).
  - SQ_ERR_EN defined: sum_sq = 131328.
- Exhaustive sweep:
  - Stimulus: all 65536 (A,B) pairs with R = A*B, last on the final pair.
  - Required: sample_count = 65536, err_count = 0, ovf = 0.
- Handshake:
  - Stimulus: in_valid toggled 1-0-0-1-1; in_valid held in IDLE and DONE.
  - Required: only samples accepted in RUN are counted; in_ready = 0 in IDLE/DRAIN/DONE.
- Saturation:
  - Stimulus: SUM_W = 16; 2 samples each with ED = 40000.
  - Required: sum_ed = 65535, ovf = 1, sticky until the next start.
- Reset/restart:
  - Stimulus: assert rst_n low mid-frame after 3 samples.
  - Required: all outputs 0 immediately, state IDLE.
  - Stimulus: start while in DONE.
  - Required: out_valid drops the next cycle and counters read 0.
